// File: rtl/atanh_dispatch_if.sv
// atanh_dispatch_if: input stream, core handshake and output stream bundle for atanh_dispatch
interface atanh_dispatch_if #(parameter int DW = 9);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          cordic_trig;
  logic [DW-1:0] cordic_tanha;
  logic          cordic_vld;
  logic [DW-1:0] cordic_a;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sat;
  logic          out_err;
  modport master (
    output in_valid, in_data, cordic_vld, cordic_a, out_ready,
    input  in_ready, cordic_trig, cordic_tanha, out_valid, out_data, out_sat, out_err
  );
  modport slave (
    input  in_valid, in_data, cordic_vld, cordic_a, out_ready,
    output in_ready, cordic_trig, cordic_tanha, out_valid, out_data, out_sat, out_err
  );
endinterface

// File: rtl/atanh_dispatch.sv
// atanh_dispatch: FIFO-buffered, clamping, one-in-flight front-end for the atanh CORDIC core
module atanh_dispatch #(
  parameter int DW      = 9,
  parameter int DEPTH   = 4,
  parameter int SAT_LIM = 255,
  parameter int TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  atanh_dispatch_if.slave io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic signed [DW-1:0] LIM_P = DW'(SAT_LIM);
  localparam logic signed [DW-1:0] LIM_N = DW'(-SAT_LIM);
  typedef enum logic [1:0] {IDLE, TRIG, WAIT, OUT} state_t;
  state_t        r_state, w_next;
  logic [DW:0]   r_mem [DEPTH];
  logic [AW:0]   r_wp, r_rp;
  logic [DW-1:0] r_tanha, r_data;
  logic          r_sat, r_err;
  logic [CW-1:0] r_cnt;
  logic          w_full, w_empty, w_push, w_pop, w_hi, w_lo, w_tmo, w_done;
  logic [DW-1:0] w_clamp;
  assign w_full  = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign w_empty = r_wp == r_rp;
  assign w_push  = io_bus.in_valid && io_bus.in_ready;
  assign w_hi    = $signed(io_bus.in_data) > LIM_P;
  assign w_lo    = $signed(io_bus.in_data) < LIM_N;
  assign w_clamp = w_hi ? LIM_P : w_lo ? LIM_N : io_bus.in_data;
  // timeout fires as the counter would step onto TIMEOUT-1, landing the error exactly TIMEOUT cycles after trig
  assign w_tmo   = (r_cnt + CW'(1)) == CW'(TIMEOUT - 1);
  assign w_done  = r_state == WAIT && (io_bus.cordic_vld || w_tmo);
  assign io_bus.in_ready     = !rst && !w_full;
  assign io_bus.cordic_trig  = r_state == TRIG;
  assign io_bus.cordic_tanha = r_tanha;
  assign io_bus.out_valid    = r_state == OUT;
  assign io_bus.out_data     = r_data;
  assign io_bus.out_sat      = r_sat;
  assign io_bus.out_err      = r_err;
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop  = !w_empty;
        w_next = w_empty ? IDLE : TRIG;
      end
      TRIG:    w_next = WAIT;
      WAIT:    w_next = w_done ? OUT : WAIT;
      default: w_next = io_bus.out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= {w_hi || w_lo, w_clamp};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_tanha <= '0;
      r_sat   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) begin
        r_rp             <= r_rp + (AW+1)'(1);
        {r_sat, r_tanha} <= r_mem[r_rp[AW-1:0]];
      end
      r_cnt <= r_state == WAIT ? r_cnt + CW'(1) : '0;
      if (w_done) begin
        r_data <= io_bus.cordic_vld ? io_bus.cordic_a : '0;
        r_err  <= !io_bus.cordic_vld;
      end
    end
  end
endmodule

// File: tb/tb_atanh_dispatch.sv
// tb_atanh_dispatch: directed scenarios against a behavioural atanh core model
module tb_atanh_dispatch;
  localparam real PI = 3.141592653589793;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  atanh_dispatch_if #(.DW(9)) bus();
  atanh_dispatch dut (.clk(clk), .rst(rst), .io_bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  int trig_cnt = 0;
  int cd = -1;
  int core_lat = 2;
  int core_mode = 0;
  bit core_on = 1'b1;
  bit core_v = 1'b0;
  bit inj_v = 1'b0;
  logic [8:0] core_val = '0;
  logic [8:0] core_a = '0;
  logic [8:0] inj_a = '0;
  assign bus.cordic_vld = core_v | inj_v;
  assign bus.cordic_a   = inj_v ? inj_a : core_a;
  function automatic logic [8:0] model(input logic [8:0] t);
    real r;
    int i;
    r = $atanh($itor($signed(t)) / 256.0) * 512.0 / PI;
    i = $rtoi(r + (r >= 0.0 ? 0.5 : -0.5));
    if (i > 255) i = 255;
    if (i < -256) i = -256;
    return 9'(i);
  endfunction
  // core model: mode 0 atanh, 1 fixed value, 2 echo operand; vld pulses core_lat cycles after trig
  always @(negedge clk) begin
    core_v = 1'b0;
    if (cd == 0) core_v = 1'b1;
    if (cd >= 0) cd--;
    if (bus.cordic_trig === 1'b1) begin
      trig_cnt++;
      if (core_on) begin
        cd = core_lat - 1;
        core_a = core_mode == 1 ? core_val : core_mode == 2 ? bus.cordic_tanha : model(bus.cordic_tanha);
      end
    end
  end
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic push(input int x);
    bus.in_valid = 1'b1;
    bus.in_data  = 9'(x);
    cyc();
    bus.in_valid = 1'b0;
  endtask
  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_cmp++;
    if ({bus.in_ready, bus.cordic_trig, bus.cordic_tanha, bus.out_valid, bus.out_data, bus.out_sat, bus.out_err} !== 23'd0) begin
      n_bad++;
      $display("FAIL rst_outputs: got rdy=%b trig=%b tanha=%0d ov=%b od=%0d sat=%b err=%b want all 0",
               bus.in_ready, bus.cordic_trig, bus.cordic_tanha, bus.out_valid, bus.out_data, bus.out_sat, bus.out_err);
    end
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", bus.in_ready); end
  endtask
  task automatic test_zero();
    int t0;
    t0 = trig_cnt;
    core_mode = 0;
    core_lat = 2;
    push(0);
    n_cmp++;
    if (bus.cordic_trig !== 1'b0) begin n_bad++; $display("FAIL t1_trig_early: got %b want 0", bus.cordic_trig); end
    cyc();
    n_cmp++;
    if ({bus.cordic_trig, bus.cordic_tanha} !== {1'b1, 9'd0}) begin
      n_bad++; $display("FAIL t1_trig: got trig=%b tanha=%0d want trig=1 tanha=0", bus.cordic_trig, bus.cordic_tanha);
    end
    cyc();
    cyc();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_ov_early: got %b want 0", bus.out_valid); end
    cyc();
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_sat, bus.out_err} !== {1'b1, 9'd0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL t1_out: got ov=%b od=%0d sat=%b err=%b want 1/0/0/0", bus.out_valid, bus.out_data, bus.out_sat, bus.out_err);
    end
    cyc();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL t1_ov_drop: got %b want 0", bus.out_valid); end
    n_cmp++;
    if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL t1_trig_count: got %0d want 1", trig_cnt - t0); end
  endtask
  task automatic test_clamp();
    int xs [4] = '{-256, -255, 255, -100};
    int ts [4] = '{-255, -255, 255, -100};
    int as [4] = '{-62, 17, -1, 100};
    bit ss [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit ok;
    core_mode = 1;
    for (int k = 0; k < 4; k++) begin
      core_val = 9'(as[k]);
      push(xs[k]);
      cyc();
      n_cmp++;
      if ({bus.cordic_trig, bus.cordic_tanha} !== {1'b1, 9'(ts[k])}) begin
        n_bad++; $display("FAIL t2_tanha x=%0d: got trig=%b tanha=%0d want trig=1 tanha=%0d",
                          xs[k], bus.cordic_trig, $signed(bus.cordic_tanha), ts[k]);
      end
      wait_out(ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL t2_wait x=%0d: got no out_valid want out_valid within 200 cycles", xs[k]); end
      n_cmp++;
      if ({bus.out_data, bus.out_sat, bus.out_err} !== {9'(as[k]), ss[k], 1'b0}) begin
        n_bad++; $display("FAIL t2_out x=%0d: got od=%0d sat=%b err=%b want od=%0d sat=%b err=0",
                          xs[k], $signed(bus.out_data), bus.out_sat, bus.out_err, as[k], ss[k]);
      end
      cyc();
    end
  endtask
  task automatic test_back_to_back();
    int v [6] = '{10, 20, 30, 40, 50, 60};
    int acc, blocked, nout, t0;
    bit took;
    t0 = trig_cnt;
    core_mode = 2;
    core_lat = 1;
    bus.out_ready = 1'b0;
    acc = 0;
    blocked = -1;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 20 && blocked < 0; c++) begin
      bus.in_data = 9'(v[acc]);
      if (bus.in_ready) acc++;
      else blocked = acc;
      if (blocked < 0) cyc();
    end
    n_cmp++;
    if (blocked !== 5) begin n_bad++; $display("FAIL t3_accepts_before_full: got %0d want 5", blocked); end
    bus.out_ready = 1'b1;
    took = 1'b0;
    nout = 0;
    for (int c = 0; c < 300 && nout < 6; c++) begin
      if (took) bus.in_valid = 1'b0;
      else if (bus.in_ready) took = 1'b1;
      if (bus.out_valid) begin
        n_cmp++;
        if (bus.out_data !== 9'(v[nout])) begin
          n_bad++; $display("FAIL t3_order[%0d]: got %0d want %0d", nout, bus.out_data, v[nout]);
        end
        nout++;
      end
      cyc();
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (nout !== 6) begin n_bad++; $display("FAIL t3_outputs: got %0d want 6", nout); end
    n_cmp++;
    if (trig_cnt - t0 !== 6) begin n_bad++; $display("FAIL t3_trigs: got %0d want 6", trig_cnt - t0); end
  endtask
  task automatic test_timeout();
    int t0;
    bit ok;
    t0 = trig_cnt;
    core_on = 1'b0;
    push(33);
    cyc();
    n_cmp++;
    if (bus.cordic_trig !== 1'b1) begin n_bad++; $display("FAIL t4_trig: got %b want 1", bus.cordic_trig); end
    repeat (63) cyc();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL t4_early: got ov=%b want 0 at trig+63", bus.out_valid); end
    cyc();
    n_cmp++;
    if ({bus.out_valid, bus.out_err, bus.out_data, bus.out_sat} !== {1'b1, 1'b1, 9'd0, 1'b0}) begin
      n_bad++; $display("FAIL t4_err: got ov=%b err=%b od=%0d sat=%b want 1/1/0/0 at trig+64",
                        bus.out_valid, bus.out_err, bus.out_data, bus.out_sat);
    end
    cyc();
    inj_a = 9'd77;
    inj_v = 1'b1;
    cyc();
    cyc();
    inj_v = 1'b0;
    cyc();
    n_cmp++;
    if ({bus.out_valid, bus.out_data} !== {1'b0, 9'd0}) begin
      n_bad++; $display("FAIL t4_late_vld: got ov=%b od=%0d want ov=0 od=0", bus.out_valid, bus.out_data);
    end
    n_cmp++;
    if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL t4_trigs: got %0d want 1", trig_cnt - t0); end
    core_on = 1'b1;
    core_mode = 2;
    push(5);
    wait_out(ok);
    n_cmp++;
    if (!ok || {bus.out_data, bus.out_err} !== {9'd5, 1'b0}) begin
      n_bad++; $display("FAIL t4_recover: got ok=%b od=%0d err=%b want ok=1 od=5 err=0", ok, bus.out_data, bus.out_err);
    end
    cyc();
  endtask
  task automatic test_reset_mid();
    int t0;
    t0 = trig_cnt;
    core_on = 1'b0;
    push(40);
    push(50);
    cyc();
    rst = 1'b1;
    cyc();
    n_cmp++;
    if ({bus.in_ready, bus.cordic_trig, bus.cordic_tanha, bus.out_valid, bus.out_data, bus.out_sat, bus.out_err} !== 23'd0) begin
      n_bad++; $display("FAIL t5_reset_outputs: got rdy=%b trig=%b tanha=%0d ov=%b od=%0d sat=%b err=%b want all 0",
                        bus.in_ready, bus.cordic_trig, bus.cordic_tanha, bus.out_valid, bus.out_data, bus.out_sat, bus.out_err);
    end
    rst = 1'b0;
    inj_a = 9'd99;
    inj_v = 1'b1;
    cyc();
    cyc();
    inj_v = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.out_data, bus.cordic_tanha} !== {1'b1, 1'b0, 9'd0, 9'd0}) begin
      n_bad++; $display("FAIL t5_after: got rdy=%b ov=%b od=%0d tanha=%0d want 1/0/0/0",
                        bus.in_ready, bus.out_valid, bus.out_data, bus.cordic_tanha);
    end
    n_cmp++;
    if (trig_cnt - t0 !== 1) begin n_bad++; $display("FAIL t5_fifo_flushed: got %0d trigs want 1", trig_cnt - t0); end
    core_on = 1'b1;
  endtask
  task automatic test_sweep();
    bit ok;
    real e;
    core_mode = 0;
    core_lat = 3;
    for (int x = -256; x < 256; x++) begin
      push(x);
      wait_out(ok);
      e = $atanh($itor(x < -255 ? -255 : x) / 256.0) * 512.0 / PI;
      if (e > 255.0) e = 255.0;
      if (e < -256.0) e = -256.0;
      n_cmp++;
      if (!ok || ($itor($signed(bus.out_data)) - e > 2.0) || (e - $itor($signed(bus.out_data)) > 2.0)) begin
        n_bad++; $display("FAIL t6_val x=%0d: got ok=%b od=%0d want %0f +/-2", x, ok, $signed(bus.out_data), e);
      end
      n_cmp++;
      if ({bus.out_sat, bus.out_err} !== {x == -256, 1'b0}) begin
        n_bad++; $display("FAIL t6_flags x=%0d: got sat=%b err=%b want sat=%b err=0", x, bus.out_sat, bus.out_err, x == -256);
      end
      cyc();
    end
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_zero();
    test_clamp();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
